// File: rtl/fp_pkg.sv
// fp_pkg: op encodings, format widths and IEEE-754 classification helpers.
// FP_COMPARE_INVALID_EN adds the invalid flag to the in-flight bundle.
package fp_pkg;

   localparam int FP_D_EXP_W = 11;
   localparam int FP_D_MAN_W = 52;
   localparam int FP_S_EXP_W = 8;
   localparam int FP_S_MAN_W = 23;
   localparam int FP_MAX_W   = 64;

   localparam logic [2:0] FP_CMP_EQ = 3'd0;
   localparam logic [2:0] FP_CMP_LT = 3'd1;
   localparam logic [2:0] FP_CMP_LE = 3'd2;
   localparam logic [2:0] FP_CMP_GT = 3'd3;
   localparam logic [2:0] FP_CMP_GE = 3'd4;
   localparam logic [2:0] FP_CMP_NE = 3'd5;
   localparam logic [2:0] FP_CMP_UN = 3'd6;

   // Bundle carried through the pipe once the magnitude compare is done.
   typedef struct packed {
      logic [2:0] op;
      logic       unord;
`ifdef FP_COMPARE_INVALID_EN
      logic       inv;
`endif
      logic       lt;
      logic       eq;
      logic       gt;
   } cmp_mid_t;

   function automatic logic [FP_MAX_W-1:0] fp_mask(input int unsigned w);
      return (FP_MAX_W'(1) << w) - FP_MAX_W'(1);
   endfunction

   function automatic logic is_nan(input logic [FP_MAX_W-1:0] x,
                                   input int unsigned exp_w,
                                   input int unsigned man_w);
      logic [FP_MAX_W-1:0] e;
      logic [FP_MAX_W-1:0] m;
      e = (x >> man_w) & fp_mask(exp_w);
      m = x & fp_mask(man_w);
      return (e == fp_mask(exp_w)) && (m != '0);
   endfunction

   function automatic logic is_snan(input logic [FP_MAX_W-1:0] x,
                                    input int unsigned exp_w,
                                    input int unsigned man_w);
      return is_nan(x, exp_w, man_w) && !x[man_w-1];
   endfunction

   function automatic logic is_zero(input logic [FP_MAX_W-1:0] x,
                                    input int unsigned exp_w,
                                    input int unsigned man_w);
      return (x & fp_mask(exp_w + man_w)) == '0;
   endfunction

endpackage

// File: rtl/fp_pipe_slot.sv
// fp_pipe_slot: one elastic register slot with valid bit and
// pass-through ready so bubbles collapse.
module fp_pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: pipelined IEEE-754 comparator with six predicates.
// Define FP_COMPARE_INVALID_EN to add the out_invalid flag.
module fp_compare_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W  = FP_D_EXP_W,
   parameter int MAN_W  = FP_D_MAN_W,
   parameter int STAGES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic [2:0]             op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_z,
   output logic                   out_unord
`ifdef FP_COMPARE_INVALID_EN
   ,
   output logic                   out_invalid
`endif
);

   localparam int W  = EXP_W + MAN_W + 1;
   localparam int PW = $bits(cmp_mid_t);

   logic [FP_MAX_W-1:0] ax;
   logic [FP_MAX_W-1:0] bx;
   logic                sa;
   logic                sb;
   logic [W-2:0]        ma;
   logic [W-2:0]        mb;
   logic                mag_lt;
   logic                mag_eq;
   logic                zz;
   cmp_mid_t            mid;

   assign ax     = FP_MAX_W'(a);
   assign bx     = FP_MAX_W'(b);
   assign sa     = a[W-1];
   assign sb     = b[W-1];
   assign ma     = a[W-2:0];
   assign mb     = b[W-2:0];
   assign mag_lt = ma < mb;
   assign mag_eq = ma == mb;
   assign zz     = is_zero(ax, EXP_W, MAN_W) && is_zero(bx, EXP_W, MAN_W);

   // Sign-magnitude ordering; NaN leaves lt/eq/gt all clear.
   always_comb begin
      mid       = '0;
      mid.op    = op;
      mid.unord = is_nan(ax, EXP_W, MAN_W) || is_nan(bx, EXP_W, MAN_W);
      if (mid.unord) begin
         mid.eq = 1'b0;
      end else if (zz) begin
         mid.eq = 1'b1;
      end else if (sa != sb) begin
         mid.lt = sa;
         mid.gt = sb;
      end else if (!sa) begin
         mid.lt = mag_lt;
         mid.eq = mag_eq;
         mid.gt = !mag_lt && !mag_eq;
      end else begin
         mid.lt = !mag_lt && !mag_eq;
         mid.eq = mag_eq;
         mid.gt = mag_lt;
      end
`ifdef FP_COMPARE_INVALID_EN
      mid.inv = is_snan(ax, EXP_W, MAN_W) || is_snan(bx, EXP_W, MAN_W) ||
                (mid.unord && (op == FP_CMP_LT || op == FP_CMP_LE ||
                               op == FP_CMP_GT || op == FP_CMP_GE));
`endif
   end

   logic [STAGES:0] v;
   logic [STAGES:0] r;
   cmp_mid_t        d [STAGES+1];

   assign v[0]      = in_valid;
   assign d[0]      = mid;
   assign r[STAGES] = out_ready;
   assign in_ready  = r[0];

   for (genvar i = 0; i < STAGES; i++) begin : g_slot
      fp_pipe_slot #(
         .W (PW)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (v[i]),
         .in_ready  (r[i]),
         .in_data   (d[i]),
         .out_valid (v[i+1]),
         .out_ready (r[i+1]),
         .out_data  (d[i+1])
      );
   end

   cmp_mid_t q;
   logic     z;

   assign q = d[STAGES];

   always_comb begin
      z = 1'b0;
      unique case (1'b1)
         (q.op == FP_CMP_EQ): z = q.eq;
         (q.op == FP_CMP_LT): z = q.lt;
         (q.op == FP_CMP_LE): z = q.lt || q.eq;
         (q.op == FP_CMP_GT): z = q.gt;
         (q.op == FP_CMP_GE): z = q.gt || q.eq;
         (q.op == FP_CMP_NE): z = !q.eq;
         (q.op == FP_CMP_UN): z = q.unord;
         default:             z = 1'b0;
      endcase
   end

   assign out_valid = v[STAGES];
   assign out_z     = v[STAGES] && z;
   assign out_unord = v[STAGES] && q.unord;
`ifdef FP_COMPARE_INVALID_EN
   assign out_invalid = v[STAGES] && q.inv;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: double/STAGES=2 and single/STAGES=1 instances
// checked against an integer-key ordering model.
module tb_fp_compare_pipe;
   import fp_pkg::*;

   localparam int DE = FP_D_EXP_W;
   localparam int DM = FP_D_MAN_W;
   localparam int DS = 2;
   localparam int SE = FP_S_EXP_W;
   localparam int SM = FP_S_MAN_W;
   localparam int SS = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_out_ready = 1'b1;
   logic [63:0] d_a = '0, d_b = '0;
   logic [2:0]  d_op = '0;
   logic        d_z, d_unord, d_inv;
   logic        s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
   logic [31:0] s_a = '0, s_b = '0;
   logic [2:0]  s_op = '0;
   logic        s_z, s_unord, s_inv;

   fp_compare_pipe #(.EXP_W(DE), .MAN_W(DM), .STAGES(DS)) u_dbl (
      .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .a(d_a), .b(d_b), .op(d_op), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .out_z(d_z), .out_unord(d_unord)
`ifdef FP_COMPARE_INVALID_EN
      , .out_invalid(d_inv)
`endif
   );

   fp_compare_pipe #(.EXP_W(SE), .MAN_W(SM), .STAGES(SS)) u_sgl (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_z(s_z), .out_unord(s_unord)
`ifdef FP_COMPARE_INVALID_EN
      , .out_invalid(s_inv)
`endif
   );

`ifndef FP_COMPARE_INVALID_EN
   assign d_inv = 1'b0;
   assign s_inv = 1'b0;
`endif

   int passed = 0;
   int total = 0;

   typedef struct {
      logic z;
      logic u;
      logic i;
   } res_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [2:0]  op;
      logic        z;
      logic        u;
      logic        i;
   } vec_t;

   vec_t vt [18] = '{
      '{64'h3FF0000000000000, 64'h4000000000000000, 3'd1, 1'b1, 1'b0, 1'b0},
      '{64'h3FF0000000000000, 64'h4000000000000000, 3'd4, 1'b0, 1'b0, 1'b0},
      '{64'h8000000000000000, 64'h0000000000000000, 3'd0, 1'b1, 1'b0, 1'b0},
      '{64'h8000000000000000, 64'h0000000000000000, 3'd2, 1'b1, 1'b0, 1'b0},
      '{64'h8000000000000000, 64'h0000000000000000, 3'd1, 1'b0, 1'b0, 1'b0},
      '{64'h8000000000000000, 64'h0000000000000000, 3'd5, 1'b0, 1'b0, 1'b0},
      '{64'hBFF0000000000000, 64'hC000000000000000, 3'd3, 1'b1, 1'b0, 1'b0},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd0, 1'b0, 1'b1, 1'b0},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd1, 1'b0, 1'b1, 1'b1},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd2, 1'b0, 1'b1, 1'b1},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd3, 1'b0, 1'b1, 1'b1},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd4, 1'b0, 1'b1, 1'b1},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd5, 1'b1, 1'b1, 1'b0},
      '{64'h7FF8000000000000, 64'h3FF0000000000000, 3'd6, 1'b1, 1'b1, 1'b0},
      '{64'h7FF0000000000001, 64'h3FF0000000000000, 3'd0, 1'b0, 1'b1, 1'b1},
      '{64'h0000000000000001, 64'h0000000000000000, 3'd3, 1'b1, 1'b0, 1'b0},
      '{64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 3'd3, 1'b1, 1'b0, 1'b0},
      '{64'h3FF0000000000000, 64'h4000000000000000, 3'd7, 1'b0, 1'b0, 1'b0}
   };

   // Reference: map each ordered value to a signed integer key.
   function automatic res_t ref_cmp(input logic [63:0] a, input logic [63:0] b,
                                    input logic [2:0] op, input int ew, input int mw);
      int          w = ew + mw + 1;
      logic [63:0] em = (64'd1 << ew) - 1;
      logic [63:0] mm = (64'd1 << mw) - 1;
      logic [63:0] gm = (64'd1 << (w - 1)) - 1;
      logic        na = (((a >> mw) & em) == em) && ((a & mm) != 0);
      logic        nb = (((b >> mw) & em) == em) && ((b & mm) != 0);
      logic        sna = na && !a[mw-1];
      logic        snb = nb && !b[mw-1];
      longint      ka = a[w-1] ? -longint'(a & gm) : longint'(a & gm);
      longint      kb = b[w-1] ? -longint'(b & gm) : longint'(b & gm);
      logic        un = na || nb;
      logic        lt = !un && (ka < kb);
      logic        eq = !un && (ka == kb);
      logic        gt = !un && (ka > kb);
      res_t        r;
      case (op)
         3'd0:    r.z = eq;
         3'd1:    r.z = lt;
         3'd2:    r.z = lt || eq;
         3'd3:    r.z = gt;
         3'd4:    r.z = gt || eq;
         3'd5:    r.z = !eq;
         3'd6:    r.z = un;
         default: r.z = 1'b0;
      endcase
      r.u = un;
`ifdef FP_COMPARE_INVALID_EN
      r.i = sna || snb || (un && op >= 3'd1 && op <= 3'd4);
`else
      r.i = 1'b0;
`endif
      return r;
   endfunction

   function automatic logic [63:0] rand_val(input int ew, input int mw);
      logic [63:0] em = (64'd1 << ew) - 1;
      logic [63:0] sg = 64'd1 << (ew + mw);
      logic [63:0] full = (64'd1 << (ew + mw + 1)) - 1;
      logic [63:0] r = {$urandom, $urandom} & full;
      case ($urandom_range(0, 9))
         0:       return 64'd0;
         1:       return sg;
         2:       return em << mw;
         3:       return sg | (em << mw);
         4:       return (em << mw) | (64'd1 << (mw - 1)) | (r & ((64'd1 << (mw - 1)) - 1));
         5:       return (em << mw) | 64'd1;
         6:       return (r & sg) | 64'd1;
         default: return r;
      endcase
   endfunction

   task automatic gen_pair(input int ew, input int mw, output logic [63:0] a,
                           output logic [63:0] b, output logic [2:0] op);
      a = rand_val(ew, mw);
      b = rand_val(ew, mw);
      if ($urandom_range(0, 4) == 0) b = a;
      else if ($urandom_range(0, 7) == 0) b = a ^ (64'd1 << (ew + mw));
      op = 3'($urandom_range(0, 7));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({d_in_ready, s_in_ready} !== 2'b11) begin
         $display("FAIL reset_in_ready got %b want 11", {d_in_ready, s_in_ready});
      end else passed++;
      total++;
      if ({d_out_valid, d_z, d_unord, s_out_valid, s_z, s_unord} !== 6'b0) begin
         $display("FAIL reset_outputs got %b want 000000",
                  {d_out_valid, d_z, d_unord, s_out_valid, s_z, s_unord});
      end else passed++;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      for (int n = 0; n < 18; n++) begin
         d_a = vt[n].a;
         d_b = vt[n].b;
         d_op = vt[n].op;
         d_in_valid = 1'b1;
         d_out_ready = 1'b1;
         #1;
         total++;
         if (d_in_ready !== 1'b1) begin
            $display("FAIL dir_in_ready[%0d] got %b want 1", n, d_in_ready);
         end else passed++;
         @(posedge clk);
         #1;
         d_in_valid = 1'b0;
         for (int k = 1; k < DS; k++) begin
            total++;
            if (d_out_valid !== 1'b0) begin
               $display("FAIL dir_early[%0d] got %b want 0", n, d_out_valid);
            end else passed++;
            @(posedge clk);
            #1;
         end
         total++;
         if ({d_out_valid, d_z, d_unord} !== {1'b1, vt[n].z, vt[n].u}) begin
            $display("FAIL dir_result[%0d] got v/z/u %b want %b", n,
                     {d_out_valid, d_z, d_unord}, {1'b1, vt[n].z, vt[n].u});
         end else passed++;
`ifdef FP_COMPARE_INVALID_EN
         total++;
         if (d_inv !== vt[n].i) begin
            $display("FAIL dir_invalid[%0d] got %b want %b", n, d_inv, vt[n].i);
         end else passed++;
`endif
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0: fixed 5-cycle stall window; mode 1: random valid/ready.
   task automatic test_stream(input int n, input int mode);
      int          sent = 0;
      int          recv = 0;
      int          cyc = 0;
      int          occ;
      logic        stall_prev = 1'b0;
      logic        hz = 1'b0;
      logic        hu = 1'b0;
      logic [63:0] pa, pb;
      logic [2:0]  pop;
      res_t        q [$];
      res_t        e;
      gen_pair(DE, DM, pa, pb, pop);
      while (recv < n && cyc < n * 10 + 50) begin
         d_a = pa;
         d_b = pb;
         d_op = pop;
         d_in_valid = (sent < n) && (mode == 0 || $urandom_range(0, 3) != 0);
         d_out_ready = (mode == 0) ? !(cyc >= 4 && cyc < 9) : ($urandom_range(0, 2) != 0);
         #1;
         occ = sent - recv;
         total++;
         if (d_in_ready !== ((occ < DS) || d_out_ready)) begin
            $display("FAIL in_ready_rule cyc %0d got %b want %b", cyc, d_in_ready,
                     (occ < DS) || d_out_ready);
         end else passed++;
         if (stall_prev) begin
            total++;
            if ({d_out_valid, d_z, d_unord} !== {1'b1, hz, hu}) begin
               $display("FAIL stall_hold cyc %0d got %b want %b", cyc,
                        {d_out_valid, d_z, d_unord}, {1'b1, hz, hu});
            end else passed++;
         end
         if (d_out_valid && d_out_ready) begin
            total++;
            if (q.size() == 0) begin
               $display("FAIL stream_extra cyc %0d got beat want none", cyc);
            end else begin
               e = q.pop_front();
               if ({d_z, d_unord, d_inv} !== {e.z, e.u, e.i}) begin
                  $display("FAIL stream_result beat %0d got z/u/i %b want %b", recv,
                           {d_z, d_unord, d_inv}, {e.z, e.u, e.i});
               end else passed++;
            end
            recv++;
         end
         stall_prev = d_out_valid && !d_out_ready;
         hz = d_z;
         hu = d_unord;
         if (d_in_valid && d_in_ready) begin
            q.push_back(ref_cmp(pa, pb, pop, DE, DM));
            sent++;
            gen_pair(DE, DM, pa, pb, pop);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      total++;
      if (recv != n || q.size() != 0) begin
         $display("FAIL stream_count got %0d left %0d want %0d left 0", recv, q.size(), n);
      end else passed++;
      d_in_valid = 1'b0;
      d_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         total++;
         if (d_out_valid !== 1'b0) begin
            $display("FAIL stream_dup got %b want 0", d_out_valid);
         end else passed++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset_midstream();
      res_t e;
      d_out_ready = 1'b1;
      d_op = FP_CMP_LT;
      d_a = 64'h3FF0000000000000;
      d_b = 64'h4000000000000000;
      d_in_valid = 1'b1;
      @(posedge clk);
      #1;
      d_op = FP_CMP_LE;
      @(posedge clk);
      #1;
      d_in_valid = 1'b0;
      d_out_ready = 1'b0;
      total++;
      if ({d_out_valid, d_z} !== 2'b11) begin
         $display("FAIL rst_prefill got %b want 11", {d_out_valid, d_z});
      end else passed++;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      d_out_ready = 1'b1;
      total++;
      if ({d_out_valid, d_z, d_unord, d_in_ready} !== 4'b0001) begin
         $display("FAIL rst_flush got %b want 0001", {d_out_valid, d_z, d_unord, d_in_ready});
      end else passed++;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         total++;
         if (d_out_valid !== 1'b0) begin
            $display("FAIL rst_stale got %b want 0", d_out_valid);
         end else passed++;
      end
      d_a = 64'hC000000000000000;
      d_b = 64'hBFF0000000000000;
      d_op = FP_CMP_LT;
      e = ref_cmp(d_a, d_b, d_op, DE, DM);
      d_in_valid = 1'b1;
      @(posedge clk);
      #1;
      d_in_valid = 1'b0;
      for (int k = 1; k < DS; k++) begin
         total++;
         if (d_out_valid !== 1'b0) begin
            $display("FAIL rst_latency_early got %b want 0", d_out_valid);
         end else passed++;
         @(posedge clk);
         #1;
      end
      total++;
      if ({d_out_valid, d_z, d_unord} !== {1'b1, e.z, e.u}) begin
         $display("FAIL rst_latency got %b want %b", {d_out_valid, d_z, d_unord},
                  {1'b1, e.z, e.u});
      end else passed++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      logic [63:0] pa, pb;
      logic [2:0]  pop;
      res_t        e, prev;
      logic [31:0] da [4] = '{32'h00000001, 32'h7F800000, 32'h80000000, 32'h7FC00000};
      logic [31:0] db [4] = '{32'h00000000, 32'h7F7FFFFF, 32'h00000000, 32'h3F800000};
      logic [2:0]  dop [4] = '{3'd3, 3'd3, 3'd0, 3'd5};
      s_out_ready = 1'b0;
      s_a = 32'h3F800000;
      s_b = 32'h40000000;
      s_op = FP_CMP_LT;
      s_in_valid = 1'b1;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      total++;
      if ({s_out_valid, s_z, s_in_ready} !== 3'b110) begin
         $display("FAIL sgl_full got %b want 110", {s_out_valid, s_z, s_in_ready});
      end else passed++;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_out_ready = 1'b1;
      total++;
      if ({s_out_valid, s_z, s_unord} !== 3'b000) begin
         $display("FAIL sgl_rst_flush got %b want 000", {s_out_valid, s_z, s_unord});
      end else passed++;
      prev = '{1'b0, 1'b0, 1'b0};
      for (int i = 0; i <= 40; i++) begin
         if (i < 4) begin
            pa = 64'(da[i]);
            pb = 64'(db[i]);
            pop = dop[i];
         end else begin
            gen_pair(SE, SM, pa, pb, pop);
         end
         s_a = pa[31:0];
         s_b = pb[31:0];
         s_op = pop;
         s_in_valid = (i < 40);
         e = ref_cmp(pa, pb, pop, SE, SM);
         #1;
         if (i > 0) begin
            total++;
            if ({s_out_valid, s_z, s_unord, s_inv, s_in_ready} !==
                {1'b1, prev.z, prev.u, prev.i, 1'b1}) begin
               $display("FAIL sgl_result beat %0d got v/z/u/i/r %b want %b", i - 1,
                        {s_out_valid, s_z, s_unord, s_inv, s_in_ready},
                        {1'b1, prev.z, prev.u, prev.i, 1'b1});
            end else passed++;
         end
         prev = e;
         @(posedge clk);
         #1;
      end
      s_in_valid = 1'b0;
      total++;
      if (s_out_valid !== 1'b0) begin
         $display("FAIL sgl_drain got %b want 0", s_out_valid);
      end else passed++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stream(8, 0);
      test_stream(200, 1);
      test_reset_midstream();
      test_single();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined IEEE-754 binary floating-point comparator with a runtime-selectable predicate and valid/ready flow control.
- Generalises the fixed double-precision less-or-equal comparator: configurable format widths, six predicates, explicit unordered (NaN) result and backpressure-capable elastic pipeline.
- Sits in the floating-point library beside the add/mul/convert blocks; consumed by sort, max/min and branch-condition logic.

Parameters:
- EXP_W, 11, exponent field width (8 = single, 11 = double)
- MAN_W, 52, stored mantissa width (23 = single, 52 = double)
- STAGES, 2, pipeline register stages (1..4); the compare is split after the magnitude-compare step when STAGES >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand/op beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  EXP_W+MAN_W+1  operand A, IEEE bit layout {sign, exp, man}
- b  in  EXP_W+MAN_W+1  operand B
- op  in  3  predicate: 0 EQ, 1 LT, 2 LE, 3 GT, 4 GE, 5 NE, 6 UN (unordered), 7 reserved
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out_z  out  1  predicate result (A op B)
- out_unord  out  1  A or B is NaN

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low. While rst_n=0 at a clk edge, all stage valid bits clear; out_valid=0, out_z=0, out_unord=0 from the following cycle. Beats in flight are discarded. in_ready=1 during and after reset (see ready rule).
- Classification: NaN = exp all-ones and man != 0. Infinity = exp all-ones and man == 0. Zero = exp == 0 and man == 0. Subnormals compare by raw magnitude; no flush.
- Ordering: +0 and -0 are equal. Otherwise use sign-magnitude ordering on raw bits:
  - Signs differ: the negative operand is less.
  - Both positive: compare {exp, man} unsigned.
  - Both negative: reverse the unsigned {exp, man} comparison.
- Result: derive lt, eq, gt, then select by op.
  - If unordered: EQ, LT, LE, GT, GE → 0; NE → 1; UN → 1.
  - If ordered: UN → 0.
  - op=7: out_z=0.
  - out_unord reflects NaN detection regardless of op.
- Pipeline: STAGES register slots, each with a valid bit. ready_i = ~valid_i | ready_{i+1}; the last slot's downstream ready is out_ready. in_ready = ready_0.
- Latency: exactly STAGES cycles from an accepted beat to out_valid when out_ready is held 1.
- Throughput: one beat per cycle.
- Ordering guarantee: no beat reordering, duplication or loss.
- Stall: out_valid=1 with out_ready=0 holds out_z/out_unord stable. Stalls propagate upstream only through full slots; bubbles collapse.
- Pipeline full and out_ready=0: in_ready=0, and in_valid is ignored.
- Simultaneous accept at input and output on a full pipeline: allowed; all slots shift.
- op is captured with the operands and travels with its beat.

Optional Feature:
- Macro: FP_COMPARE_INVALID_EN.
- When defined, adds output out_invalid (1 bit), registered alongside out_z. It is 1 when:
  - either operand is a signalling NaN (man MSB = 0, man != 0), or
  - either operand is any NaN and op is LT, LE, GT or GE (IEEE signalling predicates).
- out_invalid has the same reset value (0), latency and stall behaviour as out_z.
- When not defined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fp_pkg:
  - op encoding constants (FP_CMP_EQ..FP_CMP_UN)
  - classification helper functions (is_nan, is_snan, is_zero) parametrised by EXP_W/MAN_W
  - double/single format width constants
- One sub-module: fp_pipe_slot. It is a single elastic register slot (payload width parameter, valid bit, ready rule, synchronous active-low reset). It is instantiated STAGES times by a generate loop.

Test Plan:
- Double format, STAGES=2, out_ready=1: a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), op=LT → out_z=1, out_unord=0 exactly 2 cycles after accept. Same operands with op=GE → 0.
- a=0x8000000000000000 (-0), b=0x0000000000000000 (+0): EQ=1, LE=1, LT=0, NE=0. a=0xBFF0000000000000 (-1.0), b=0xC000000000000000 (-2.0), op=GT → 1.
- a=0x7FF8000000000000 (qNaN), b=1.0: EQ/LT/LE/GT/GE=0, NE=1, UN=1, out_unord=1. With the macro defined: LT gives out_invalid=1, EQ gives 0. a=0x7FF0000000000001 (sNaN), op=EQ → out_invalid=1.
- Edge magnitudes: a=0x0000000000000001 (min subnormal), b=+0, op=GT → 1. a=0x7FF0000000000000 (+inf), b=0x7FEFFFFFFFFFFFFF (max finite), op=GT → 1.
- Backpressure: stream 8 back-to-back beats and hold out_ready=0 for 5 cycles mid-stream. Expect in_ready=0 after 2 accepts once full, held outputs stable while stalled, all 8 results in order with none lost or duplicated.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 beats in flight. Expect out_valid=0 next cycle, no stale result emitted, and the next accepted beat appearing after STAGES cycles. Repeat with EXP_W=8, MAN_W=23, STAGES=1.
